// File: rtl/regfile_bypass_param_if.sv
// Register-file access bundle: two read ports, one write port, soft-clear control.
interface regfile_bypass_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] Read_addr_1;
    logic [DATA_W-1:0] Read_data_1;
    logic [ADDR_W-1:0] Read_addr_2;
    logic [DATA_W-1:0] Read_data_2;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_addr;
    logic [DATA_W-1:0] Write_data;
    logic              clr_req;
    logic              busy;
    logic              wr_drop;

    modport master (
        output Read_addr_1, Read_addr_2, RegWrite, Write_addr, Write_data, clr_req,
        input  Read_data_1, Read_data_2, busy, wr_drop
    );

    modport slave (
        input  Read_addr_1, Read_addr_2, RegWrite, Write_addr, Write_data, clr_req,
        output Read_data_1, Read_data_2, busy, wr_drop
    );
endinterface

// File: rtl/regfile_bypass_param.sv
// Parametrised 2R/1W register file with optional zero register, optional
// write-to-read bypass and a one-entry-per-cycle soft-clear sweep.
module regfile_bypass_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    regfile_bypass_param_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // Address compare done one bit wider so DEPTH == 2**ADDR_W is handled.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction

    // Read mux shared by both ports; priority order matters.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (state == CLEAR || !in_range(a) || (ZERO_REG && a == '0)) begin
            r = '0;
        end else if (BYPASS && wr_ok_c && bus.Write_addr == a) begin
            r = bus.Write_data;
        end else begin
            r = mem[IDX_W'(a)];
        end
        return r;
    endfunction

    // A write commits only in IDLE, in range and not aimed at the zero register.
    always_comb begin
        wr_ok_c = bus.RegWrite && (state == IDLE) && in_range(bus.Write_addr)
                  && !(ZERO_REG && bus.Write_addr == '0);
    end

    // Combinational read ports.
    always_comb begin
        rd1_c = read_port(bus.Read_addr_1);
        rd2_c = read_port(bus.Read_addr_2);
    end

    assign bus.Read_data_1 = rd1_c;
    assign bus.Read_data_2 = rd2_c;
    assign bus.busy        = (state == CLEAR);
    assign bus.wr_drop     = bus.RegWrite && !wr_ok_c;

    // Sweep sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep next-state: terminate on LAST rather than on counter wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Storage: async clear, sweep clear, or regular write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[IDX_W'(cnt)] <= '0;
        end else if (wr_ok_c) begin
            mem[IDX_W'(bus.Write_addr)] <= bus.Write_data;
        end
    end

endmodule

// File: tb/tb_regfile_bypass_param.sv
// Randomised + directed bench for regfile_bypass_param, two configurations
// driven with identical stimulus and checked against a behavioural model.
module tb_regfile_bypass_param;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic        we, clr;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_bypass_param_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
    regfile_bypass_param_if #(.DATA_W(32), .ADDR_W(5)) if_b ();

    assign if_a.Read_addr_1 = ra1;
    assign if_a.Read_addr_2 = ra2;
    assign if_a.RegWrite    = we;
    assign if_a.Write_addr  = wa;
    assign if_a.Write_data  = wd;
    assign if_a.clr_req     = clr;
    assign if_b.Read_addr_1 = ra1;
    assign if_b.Read_addr_2 = ra2;
    assign if_b.RegWrite    = we;
    assign if_b.Write_addr  = wa;
    assign if_b.Write_data  = wd;
    assign if_b.clr_req     = clr;

    regfile_bypass_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    regfile_bypass_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .ZERO_REG(1'b0), .BYPASS(1'b0))
        u_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: contents plus "entries still to clear" per config.
    logic [31:0] mdl [2][32];
    int dep [2] = '{32, 24};
    bit zr  [2] = '{1'b1, 1'b0};
    bit bp  [2] = '{1'b1, 1'b0};
    int left [2];
    int pos  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit m_accept(input int d);
        return (left[d] == 0) && we && (int'(wa) < dep[d]) && !(zr[d] && wa == 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [4:0] a);
        if (left[d] > 0) return '0;
        if (int'(a) >= dep[d]) return '0;
        if (zr[d] && a == 5'd0) return '0;
        if (bp[d] && m_accept(d) && wa == a) return wd;
        return mdl[d][a];
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mdl[d][i] = '0;
            left[d] = 0;
            pos[d]  = 0;
        end
    endtask

    task automatic m_edge();
        for (int d = 0; d < 2; d++) begin
            if (left[d] > 0) begin
                mdl[d][pos[d]] = '0;
                pos[d]++;
                left[d]--;
            end else begin
                if (m_accept(d)) mdl[d][wa] = wd;
                if (clr) begin
                    left[d] = dep[d];
                    pos[d]  = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s a.rd1", tag), if_a.Read_data_1, m_read(0, ra1));
        check($sformatf("%s a.rd2", tag), if_a.Read_data_2, m_read(0, ra2));
        check($sformatf("%s a.busy", tag), 32'(if_a.busy), 32'(left[0] > 0));
        check($sformatf("%s a.wr_drop", tag), 32'(if_a.wr_drop), 32'(we && !m_accept(0)));
        check($sformatf("%s b.rd1", tag), if_b.Read_data_1, m_read(1, ra1));
        check($sformatf("%s b.rd2", tag), if_b.Read_data_2, m_read(1, ra2));
        check($sformatf("%s b.busy", tag), 32'(if_b.busy), 32'(left[1] > 0));
        check($sformatf("%s b.wr_drop", tag), 32'(if_b.wr_drop), 32'(we && !m_accept(1)));
    endtask

    task automatic edge_only();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic step(input string tag);
        #2;
        compare_all(tag);
        edge_only();
    endtask

    task automatic idle_inputs();
        we = 1'b0; clr = 1'b0; wa = '0; wd = '0;
    endtask

    initial begin
        int busy_a, busy_b;
        rst = 1'b1; ra1 = '0; ra2 = '0;
        idle_inputs();
        m_reset();
        #12;
        compare_all("reset");
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset wipes a freshly written entry immediately.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step("wr5");
        idle_inputs(); ra1 = 5'd5;
        #2;
        check("pre_rst a.rd1", if_a.Read_data_1, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("async_rst a.rd1", if_a.Read_data_1, 32'h0);
        check("async_rst a.busy", 32'(if_a.busy), 32'h0);
        m_reset();
        #1 rst = 1'b0;
        edge_only();

        // Same-cycle write/read: bypassed on a, old value on b.
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra1 = 5'd7;
        #2;
        check("bypass a.rd1", if_a.Read_data_1, 32'h12345678);
        check("nobypass b.rd1", if_b.Read_data_1, 32'h0);
        compare_all("bypass");
        edge_only();
        idle_inputs();
        #2;
        check("after_wr b.rd1", if_b.Read_data_1, 32'h12345678);
        compare_all("after_wr");
        edge_only();

        // Zero register on a, out-of-range on b.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra2 = 5'd0;
        #2;
        check("zero a.wr_drop", 32'(if_a.wr_drop), 32'h1);
        check("zero a.rd2", if_a.Read_data_2, 32'h0);
        compare_all("zero");
        edge_only();
        we = 1'b1; wa = 5'd30; wd = 32'h0BADF00D; ra1 = 5'd30;
        #2;
        check("oor b.wr_drop", 32'(if_b.wr_drop), 32'h1);
        check("oor b.rd1", if_b.Read_data_1, 32'h0);
        compare_all("oor");
        edge_only();

        // Fill 1..31 with their index, then read everything back.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i);
            step("fill");
        end
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            step("readback");
        end

        // Soft clear launched together with a write to entry 3.
        we = 1'b1; wa = 5'd3; wd = 32'h000000A5; clr = 1'b1; ra1 = 5'd3;
        step("clr_wr");
        idle_inputs();
        busy_a = 0; busy_b = 0;
        for (int i = 0; i < 200; i++) begin
            idle_inputs();
            if (i == 5) begin we = 1'b1; wa = 5'd4; wd = 32'h55AA55AA; end
            if (i == 12) clr = 1'b1;
            ra1 = 5'($urandom); ra2 = 5'($urandom);
            #2;
            compare_all("sweep");
            if (if_a.busy) busy_a++;
            if (if_b.busy) busy_b++;
            if (!if_a.busy && !if_b.busy) break;
            edge_only();
        end
        idle_inputs();
        check("busy_len a", 32'(busy_a), 32'd32);
        check("busy_len b", 32'(busy_b), 32'd24);
        edge_only();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            #2;
            check("cleared a.rd1", if_a.Read_data_1, 32'h0);
            compare_all("cleared");
            edge_only();
        end

        // Reset in the middle of a sweep, then a normal write.
        clr = 1'b1;
        step("clr2");
        idle_inputs();
        for (int i = 0; i < 10; i++) step("sweep2");
        #2;
        rst = 1'b1;
        #1;
        check("midrst a.busy", 32'(if_a.busy), 32'h0);
        check("midrst b.busy", 32'(if_b.busy), 32'h0);
        m_reset();
        #1 rst = 1'b0;
        edge_only();
        we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D; ra1 = 5'd1;
        step("post_rst_wr");
        idle_inputs(); ra1 = 5'd9;
        #2;
        check("post_rst a.rd1", if_a.Read_data_1, 32'hCAFEF00D);
        check("post_rst b.rd1", if_b.Read_data_1, 32'hCAFEF00D);
        compare_all("post_rst");
        edge_only();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom);
            wd  = $urandom;
            clr = ($urandom_range(0, 59) == 0);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
